// File: rtl/product_word_serializer.sv
// Captures the multiplier's product when it reports done and streams it out as
// words over valid/ready, least-significant word first, then restarts the multiplier.
module product_word_serializer #(
    parameter int PROD_WIDTH = 256,
    parameter int WORD_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    localparam int NUM_WORDS = PROD_WIDTH / WORD_WIDTH,
    localparam int IDX_WIDTH = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PROD_WIDTH-1:0] prod_in,
    input  logic                  prod_done,
    output logic                  mult_reset_n,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  word_last,
    output logic [IDX_WIDTH-1:0]  word_index,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  prod_count
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SEND,
        RESTART
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_WORDS - 1);

    state_t                state;
    logic [PROD_WIDTH-1:0] shift_reg;

    // The current word is always the low slice; sending shifts the next one into place.
    assign word_out = shift_reg[WORD_WIDTH-1:0];

    // NOTE: every register here is assigned with <= so all updates see the
    // values from before the clock edge, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            shift_reg    <= '0;
            word_index   <= '0;
            prod_count   <= '0;
            mult_reset_n <= 1'b0;
            word_valid   <= 1'b0;
            word_last    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mult_reset_n <= 1'b1;
                    word_valid   <= 1'b0;
                    word_last    <= 1'b0;
                    if (prod_done) begin
                        state <= CAPTURE;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end

                // prod_in is sampled one cycle after done so the product has settled.
                CAPTURE: begin
                    shift_reg    <= prod_in;
                    word_index   <= '0;
                    word_valid   <= 1'b1;
                    word_last    <= (NUM_WORDS == 1);
                    mult_reset_n <= 1'b1;
                    busy         <= 1'b1;
                    state        <= SEND;
                end

                SEND: begin
                    mult_reset_n <= 1'b1;
                    busy         <= 1'b1;
                    if (word_valid && word_ready) begin
                        shift_reg <= shift_reg >> WORD_WIDTH;
                        if (word_index == LAST_IDX) begin
                            word_index   <= '0;
                            prod_count   <= prod_count + 1'b1;
                            word_valid   <= 1'b0;
                            word_last    <= 1'b0;
                            mult_reset_n <= 1'b0;
                            state        <= RESTART;
                        end else begin
                            word_index <= word_index + 1'b1;
                            word_last  <= ((word_index + 1'b1) == LAST_IDX);
                        end
                    end
                end

                // One-cycle reset pulse to the multiplier, which clears its done flag.
                RESTART: begin
                    mult_reset_n <= 1'b1;
                    word_valid   <= 1'b0;
                    word_last    <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    mult_reset_n <= 1'b0;
                    word_valid   <= 1'b0;
                    word_last    <= 1'b0;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_word_serializer.sv
// Directed bench for product_word_serializer: a vector table for the basic stream,
// then hand sequences for stalls, mid-stream reset, a multiplier model and sticky done.
module tb_product_word_serializer;

    localparam logic [255:0] P1 =
        256'h0000000800000007_0000000600000005_0000000400000003_0000000200000001;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [255:0] prod_in;
    logic         prod_done;
    logic         mult_reset_n;
    logic [31:0]  word_out;
    logic         word_valid;
    logic         word_ready = 1'b0;
    logic         word_last;
    logic [2:0]   word_index;
    logic         busy;
    logic [15:0]  prod_count;

    // Directed drive or behavioural multiplier, selected by use_model.
    logic         use_model = 1'b0;
    logic         tb_done = 1'b0;
    logic [255:0] tb_prod = P1;
    logic [127:0] m_a = 128'h3;
    logic [127:0] m_b = 128'h5;
    logic         m_done;
    logic [3:0]   m_cnt;
    logic [255:0] m_prod;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign m_prod    = 256'(m_a) * 256'(m_b);
    assign prod_in   = use_model ? m_prod : tb_prod;
    assign prod_done = use_model ? m_done : tb_done;

    always_ff @(posedge clk) begin
        if (!mult_reset_n) begin
            m_cnt  <= '0;
            m_done <= 1'b0;
        end else if (m_cnt < 4'd5) begin
            m_cnt  <= m_cnt + 1'b1;
        end else begin
            m_done <= 1'b1;
        end
    end

    product_word_serializer dut (
        .clk          (clk),
        .reset        (reset),
        .prod_in      (prod_in),
        .prod_done    (prod_done),
        .mult_reset_n (mult_reset_n),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_last    (word_last),
        .word_index   (word_index),
        .busy         (busy),
        .prod_count   (prod_count)
    );

    typedef struct {
        logic        rst;
        logic        done;
        logic        rdy;
        logic        valid;
        logic [31:0] word;
        logic        last;
        logic [2:0]  idx;
        logic        mrn;
        logic        busy;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic rst, logic done, logic rdy, logic valid,
                                logic [31:0] word, logic last, logic [2:0] idx,
                                logic mrn, logic bsy, logic [15:0] cnt);
        vec_t v;
        v.rst = rst; v.done = done; v.rdy = rdy; v.valid = valid; v.word = word;
        v.last = last; v.idx = idx; v.mrn = mrn; v.busy = bsy; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Outputs are observed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_product();
        tb_done = 1'b1;
        tick();
        tb_done = 1'b0;
        tick();
    endtask

    initial begin
        int n, send_cycles, stall, words, lasts, base, vcount;
        logic [31:0] rx[$];

        // Reset x3, release, then one product with ready held high.
        for (int i = 0; i < 3; i++) vecs[i] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        vecs[4] = mk(0, 1, 1, 0, 0, 0, 0, 1, 1, 0);
        vecs[5] = mk(0, 1, 1, 1, 1, 0, 0, 1, 1, 0);
        for (int k = 1; k < 8; k++)
            vecs[5 + k] = mk(0, 0, 1, 1, 32'(k + 1), (k == 7), 3'(k), 1, 1, 0);
        vecs[13] = mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        vecs[14] = mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 1);

        for (int i = 0; i < 15; i++) begin
            reset = vecs[i].rst; tb_done = vecs[i].done; word_ready = vecs[i].rdy;
            tick();
            check($sformatf("v%0d valid", i), 64'(word_valid), 64'(vecs[i].valid));
            check($sformatf("v%0d word", i), 64'(word_out), 64'(vecs[i].word));
            check($sformatf("v%0d last", i), 64'(word_last), 64'(vecs[i].last));
            check($sformatf("v%0d idx", i), 64'(word_index), 64'(vecs[i].idx));
            check($sformatf("v%0d mrn", i), 64'(mult_reset_n), 64'(vecs[i].mrn));
            check($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].busy));
            check($sformatf("v%0d cnt", i), 64'(prod_count), 64'(vecs[i].cnt));
        end

        // Stall three cycles at word index 3; the stream must resume without loss.
        word_ready = 1'b1;
        start_product();
        n = 0; send_cycles = 0; stall = 0;
        for (int cyc = 0; cyc < 30 && n < 8; cyc++) begin
            check("stall valid", 64'(word_valid), 64'd1);
            check("stall word", 64'(word_out), 64'(n + 1));
            check("stall idx", 64'(word_index), 64'(n));
            check("stall last", 64'(word_last), 64'(n == 7));
            send_cycles++;
            if (n == 3 && stall < 3) begin
                word_ready = 1'b0;
                stall++;
            end else begin
                word_ready = 1'b1;
                n++;
            end
            tick();
        end
        check("stall words", 64'(n), 64'd8);
        check("stall send cycles", 64'(send_cycles), 64'd11);
        check("stall restart mrn", 64'(mult_reset_n), 64'd0);
        check("stall restart valid", 64'(word_valid), 64'd0);
        check("stall count", 64'(prod_count), 64'd2);
        word_ready = 1'b0;
        tick();
        check("stall idle mrn", 64'(mult_reset_n), 64'd1);
        check("stall idle busy", 64'(busy), 64'd0);

        // Reset arriving while word 5 is on the bus aborts the product.
        word_ready = 1'b1;
        start_product();
        for (int cyc = 0; cyc < 20 && word_index != 3'd5; cyc++) tick();
        check("abort reached idx5", 64'(word_index), 64'd5);
        reset = 1'b1;
        tick();
        check("abort valid", 64'(word_valid), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        check("abort mrn", 64'(mult_reset_n), 64'd0);
        check("abort cnt", 64'(prod_count), 64'd0);
        check("abort idx", 64'(word_index), 64'd0);
        reset = 1'b0;
        vcount = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            tick();
            if (word_valid) vcount++;
        end
        check("abort no words", 64'(vcount), 64'd0);
        check("abort mrn released", 64'(mult_reset_n), 64'd1);

        // Behavioural multiplier 3*5: two products, the second after the restart pulse.
        use_model = 1'b1;
        word_ready = 1'b1;
        rx.delete();
        lasts = 0;
        for (int cyc = 0; cyc < 200 && prod_count < 16'd2; cyc++) begin
            if (word_valid && word_ready) begin
                rx.push_back(word_out);
                if (word_last) lasts++;
            end
            tick();
        end
        check("mult count", 64'(prod_count), 64'd2);
        check("mult words", 64'(rx.size()), 64'd16);
        check("mult lasts", 64'(lasts), 64'd2);
        for (int i = 0; i < rx.size(); i++)
            check($sformatf("mult word %0d", i), 64'(rx[i]), (i % 8 == 0) ? 64'd15 : 64'd0);
        use_model = 1'b0;
        tb_done = 1'b0;
        tick();
        check("mult back to idle", 64'(busy), 64'd0);

        // Done stuck high: products stream back to back, one last per eight words.
        tb_done = 1'b1;
        base = int'(prod_count);
        words = 0; lasts = 0;
        for (int cyc = 0; cyc < 60 && int'(prod_count) < base + 3; cyc++) begin
            if (word_valid && word_ready) begin
                check($sformatf("sticky word %0d", words), 64'(word_out), 64'((words % 8) + 1));
                check($sformatf("sticky last %0d", words), 64'(word_last), 64'(words % 8 == 7));
                words++;
                if (word_last) lasts++;
            end
            tick();
        end
        check("sticky count", 64'(prod_count), 64'(base + 3));
        check("sticky words", 64'(words), 64'd24);
        check("sticky lasts", 64'(lasts), 64'd3);
        tb_done = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
